regfile_writeback: RTL and testbench

Write-back sequencer for the 32-bit MIPS core: the single producer that drives the register file's write port (we3/a3/wd3). It merges single-cycle ALU results and load results from data memory onto that one port. Load results take priority, and ALU results are buffered in a small FIFO. A 32-bit busy scoreboard tells the decode stage which destination registers still have a write pending.

---
 rtl/mips_pkg.sv | 13 +
 rtl/wb_fifo.sv | 48 ++++
 rtl/regfile_writeback.sv | 97 +++++++++
 tb/tb_regfile_writeback.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths and write-back payload type for the MIPS core.
package mips_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering ALU write-back entries.
// Pointers carry one extra wrap bit to tell full from empty.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-back sequencer: merges load and ALU results onto the single
// register-file write port and tracks pending destinations in a scoreboard.
module regfile_writeback
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_rd,
  input  logic                alu_valid,
  input  logic [REG_W-1:0]    alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [REG_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                we3,
  output logic [REG_W-1:0]    a3,
  output logic [DATA_W-1:0]   wd3,
  output logic [NUM_REGS-1:0] busy,
  output logic                err
);

  wb_entry_t           alu_entry;
  wb_entry_t           head;
  wb_entry_t           sel;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                sel_valid;
  logic [NUM_REGS-1:0] busy_d;
  logic                err_hit;

  assign alu_entry = '{rd: alu_rd, data: alu_data};
  assign alu_ready = !full;
  assign push      = alu_valid && !full;
  assign pop       = !mem_valid && !empty;
  assign sel_valid = mem_valid || !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (alu_entry),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Loads win the port; queued ALU results wait behind them.
  always_comb begin
    sel = head;
    if (mem_valid) sel = '{rd: mem_rd, data: mem_data};
  end

  // Scoreboard update: a same-edge set overrides the clear.
  always_comb begin
    busy_d = busy;
    if (we3) busy_d[a3] = 1'b0;
    if (issue_valid && (issue_rd != REG_W'(0))) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_hit = 1'b0;
    if (issue_valid && (issue_rd != REG_W'(0)) && busy[issue_rd] &&
        !(we3 && (a3 == issue_rd)))
      err_hit = 1'b1;
    if (sel_valid && (sel.rd != REG_W'(0)) && !busy[sel.rd])
      err_hit = 1'b1;
    if (alu_valid && full)
      err_hit = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3  <= 1'b0;
      a3   <= '0;
      wd3  <= '0;
      busy <= '0;
      err  <= 1'b0;
    end else begin
      we3  <= sel_valid && (sel.rd != REG_W'(0));
      if (sel_valid) begin
        a3  <= sel.rd;
        wd3 <= sel.data;
      end
      busy <= busy_d;
      if (err_hit) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with hand-computed expectations.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  int k;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .we3         (we3),
    .a3          (a3),
    .wd3         (wd3),
    .busy        (busy),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid   = 1'b0; alu_rd   = '0; alu_data = '0;
    mem_valid   = 1'b0; mem_rd   = '0; mem_data = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    #2;
    release_reset();
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd = rd;
    step();
    issue_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    #1;
    apply_reset();
    check("rst_we3", 32'(we3), 32'h0);
    check("rst_a3", 32'(a3), 32'h0);
    check("rst_wd3", wd3, 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ready", 32'(alu_ready), 32'h1);

    // Reset mid-operation: three queued entries held back by rd=0 loads.
    issue(5'd2); issue(5'd3); issue(5'd4);
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hAAAA_0000;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(2 + i); alu_data = 32'(32'h50 + i);
      step();
    end
    alu_valid = 1'b0;
    check("pre_rst_busy", busy, 32'h0000_001C);
    rst_n = 1'b0;
    #1;
    check("midrst_we3", 32'(we3), 32'h0);
    check("midrst_busy", busy, 32'h0);
    check("midrst_ready", 32'(alu_ready), 32'h1);
    check("midrst_err", 32'(err), 32'h0);
    idle();
    release_reset();
    for (int i = 0; i < 3; i++) begin
      check("post_rst_nowrite", 32'(we3), 32'h0);
      step();
    end

    // Single ALU write.
    issue(5'd5);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 1'b0;
    check("alu_busy_pending", 32'(busy[5]), 32'h1);
    step();
    check("alu_we3", 32'(we3), 32'h1);
    check("alu_a3", 32'(a3), 32'h5);
    check("alu_wd3", wd3, 32'hDEAD_BEEF);
    check("alu_busy_still", 32'(busy[5]), 32'h1);
    step();
    check("alu_busy_clr", 32'(busy[5]), 32'h0);
    check("alu_we3_off", 32'(we3), 32'h0);

    // Load priority over a simultaneous ALU result.
    issue(5'd3); issue(5'd4);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h22;
    step();
    idle();
    check("prio_first_a3", 32'(a3), 32'h4);
    check("prio_first_wd3", wd3, 32'h22);
    step();
    check("prio_second_we3", 32'(we3), 32'h1);
    check("prio_second_a3", 32'(a3), 32'h3);
    check("prio_second_wd3", wd3, 32'h11);
    step();
    check("prio_busy", busy, 32'h0);

    // Full/backpressure under sustained loads.
    for (int r = 8; r <= 13; r++) issue(5'(r));
    for (int r = 16; r <= 20; r++) issue(5'(r));
    k = 0;
    for (int i = 0; i < 6; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(8 + i); mem_data = 32'(32'h200 + i);
      if (i == 4) check("full_ready_low", 32'(alu_ready), 32'h0);
      if (alu_ready && k < 5) begin
        alu_valid = 1'b1; alu_rd = 5'(16 + k); alu_data = 32'(32'h110 + k);
        k++;
      end else alu_valid = 1'b0;
      step();
      check("stall_mem_a3", 32'(a3), 32'(8 + i));
    end
    mem_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (alu_ready && k < 5) begin
        alu_valid = 1'b1; alu_rd = 5'(16 + k); alu_data = 32'(32'h110 + k);
        k++;
      end else alu_valid = 1'b0;
      step();
      check("drain_we3", 32'(we3), 32'h1);
      check("drain_a3", 32'(a3), 32'(16 + j));
      check("drain_wd3", wd3, 32'(32'h110 + j));
    end
    idle();
    step();
    check("full_err", 32'(err), 32'h0);
    check("full_busy", busy, 32'h0);

    // rd=0 is consumed without a write.
    issue(5'd0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    step();
    alu_valid = 1'b0;
    step();
    check("r0_we3", 32'(we3), 32'h0);
    check("r0_wd3", wd3, 32'hFFFF_FFFF);
    check("r0_busy", busy, 32'h0);
    check("r0_err", 32'(err), 32'h0);

    // Double issue without an intervening write.
    apply_reset();
    issue(5'd7);
    check("dbl_issue_err_pre", 32'(err), 32'h0);
    issue(5'd7);
    check("dbl_issue_err", 32'(err), 32'h1);

    // Write to a register with no pending claim.
    apply_reset();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h1;
    step();
    idle();
    check("unclaimed_err", 32'(err), 32'h1);

    // Same-edge set and clear of rd=6.
    apply_reset();
    issue(5'd6);
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h66;
    step();
    idle();
    check("same_edge_we3", 32'(we3), 32'h1);
    issue(5'd6);
    check("same_edge_busy", 32'(busy[6]), 32'h1);
    check("same_edge_err", 32'(err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
